// File: rtl/atpg_pkg.sv
// Shared types and helpers for the ATPG pattern source: state encoding,
// default feedback taps, lockup seed and the common shift/feedback step.
package atpg_pkg;
  localparam int ATPG_W = 5;
  localparam logic [ATPG_W-1:0] ATPG_TAPS   = 5'b10100;
  localparam logic [ATPG_W-1:0] LOCKUP_SEED = 5'b11111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One step of the Fibonacci register used by both the LFSR and the MISR.
  function automatic logic [ATPG_W-1:0] lfsr_step(input logic [ATPG_W-1:0] cur,
                                                  input logic [ATPG_W-1:0] taps);
    return {cur[ATPG_W-2:0], ^(cur & taps)};
  endfunction
endpackage

// File: rtl/atpg_lfsr_gen.sv
// Pseudo-random pattern source: loadable maximal-length LFSR.
module atpg_lfsr_gen
  import atpg_pkg::*;
#(
  parameter int               WIDTH = ATPG_W,
  parameter logic [WIDTH-1:0] TAPS  = ATPG_TAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] pattern
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pattern <= '0;
    else if (load)   pattern <= seed;
    else if (enable) pattern <= lfsr_step(pattern, TAPS);
  end
endmodule

// File: rtl/atpg_bist_ctrl.sv
// ATPG BIST sequencer: seeds the LFSR, runs N patterns, compacts responses in a
// MISR and checks the signature. ATPG_RESP_REG_EN registers cut_resp (adds DRAIN).
module atpg_bist_ctrl
  import atpg_pkg::*;
#(
  parameter int               WIDTH = ATPG_W,
  parameter logic [WIDTH-1:0] TAPS  = ATPG_TAPS,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic [WIDTH-1:0] golden_sig,
  input  logic [WIDTH-1:0] cut_resp,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);
`ifdef ATPG_RESP_REG_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   misr, misr_nxt, golden_q, resp, load_val;
  logic               pass_q, accept, shift, absorb, finish, cancel;
  // vld_pipe[0]: RUN this cycle; vld_pipe[STAGES]: resp belongs to a live pattern
  logic [STAGES:0]    vld_pipe;
  logic [STAGES+1:0]  vld_shift;

`ifdef ATPG_RESP_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp <= '0;
    else        resp <= cut_resp;
  end
`else
  assign resp = cut_resp;
`endif

  assign misr_nxt  = lfsr_step(misr, TAPS) ^ resp;
  assign load_val  = (seed == '0) ? LOCKUP_SEED : seed;
  assign vld_shift = {vld_pipe, state_nxt == RUN};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift     = 1'b0;
    absorb    = 1'b0;
    finish    = 1'b0;
    cancel    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = (pattern_count == '0) ? DONE : RUN;
      end
      RUN: if (abort) begin
        cancel    = 1'b1;
        state_nxt = IDLE;
      end else begin
        shift  = 1'b1;
        absorb = vld_pipe[STAGES];
        if (cnt == CNT_W'(1)) begin
`ifdef ATPG_RESP_REG_EN
          state_nxt = DRAIN;
`else
          state_nxt = DONE;
          finish    = 1'b1;
`endif
        end
      end
      DRAIN: if (abort) begin
        cancel    = 1'b1;
        state_nxt = IDLE;
      end else begin
        absorb    = 1'b1;
        finish    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      misr     <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= vld_shift[STAGES:0];
      if (accept) begin
        cnt      <= pattern_count;
        golden_q <= golden_sig;
        misr     <= '0;
        // A zero-length run completes immediately against an all-zero signature.
        pass_q   <= (pattern_count == '0) && (golden_sig == '0);
      end else begin
        if (shift)  cnt  <= cnt - CNT_W'(1);
        if (absorb) misr <= misr_nxt;
        if (finish) pass_q <= (misr_nxt == golden_q);
        if (cancel) pass_q <= 1'b0;
      end
    end
  end

  atpg_lfsr_gen #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .enable (shift),
    .seed   (load_val),
    .pattern(pattern)
  );

  assign pattern_valid = vld_pipe[0];
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign pass          = pass_q;
  assign signature     = misr;
endmodule

// File: tb/tb_atpg_bist_ctrl.sv
// Directed self-checking bench for atpg_bist_ctrl (hand-computed vectors).
module tb_atpg_bist_ctrl;
`ifdef ATPG_RESP_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0] seed = '0, golden = '0;
  logic [7:0] cnt = '0;
  logic       resp_mode = 1'b0;
  logic [4:0] pattern, signature, cut_resp;
  logic       pattern_valid, busy, done, pass;

  // Combinational CUT model: either all-zero response or echo of the pattern.
  assign cut_resp = resp_mode ? pattern : 5'd0;

  atpg_bist_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .pattern_count(cnt),
    .golden_sig   (golden),
    .cut_resp     (cut_resp),
    .pattern      (pattern),
    .pattern_valid(pattern_valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [4:0] pats[$];
  int         lat;
  logic [4:0] d_sig, d_pat;
  logic       d_pass;

  // Start a run, log live patterns, and stop at the done cycle (bounded).
  task automatic run(input logic [4:0] s, input logic [7:0] n, input logic [4:0] g);
    @(negedge clk);
    seed = s; cnt = n; golden = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    pats.delete();
    while (!done && lat < 200) begin
      if (pattern_valid) pats.push_back(pattern);
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1);
    d_sig  = signature;
    d_pass = pass;
    d_pat  = pattern;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pattern"}, pattern, 0);
    chk({tag, "_valid"}, pattern_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_sig"}, signature, 0);
  endtask

  initial begin
    logic [31:0] seen;
    int          ndist, nnz, ndone;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Single pattern, CUT echoes pattern: signature 00001.
    resp_mode = 1'b1;
    run(5'b00001, 8'd1, 5'b00001);
    chk("c_latency", lat, 2 + EXTRA);
    chk("c_npats", pats.size(), 1);
    chk("c_pat0", pats[0], 5'b00001);
    chk("c_sig", d_sig, 5'b00001);
    chk("c_pass", d_pass, 1);

    // Reset in the middle of a run clears everything at once.
    @(negedge clk);
    seed = 5'b11111; cnt = 8'd20; golden = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known sequence from all-ones seed, zero responses.
    resp_mode = 1'b0;
    run(5'b11111, 8'd4, 5'b00000);
    chk("b_latency", lat, 5 + EXTRA);
    chk("b_npats", pats.size(), 4);
    chk("b_pat0", pats[0], 5'b11111);
    chk("b_pat1", pats[1], 5'b11110);
    chk("b_pat2", pats[2], 5'b11100);
    chk("b_pat3", pats[3], 5'b11000);
    chk("b_sig", d_sig, 5'b00000);
    chk("b_pass", d_pass, 1);

    // Golden mismatch on the same response stream.
    resp_mode = 1'b1;
    run(5'b00001, 8'd1, 5'b00010);
    chk("c2_sig", d_sig, 5'b00001);
    chk("c2_pass", d_pass, 0);

    // Zero seed substitutes all-ones; full period walk.
    resp_mode = 1'b0;
    run(5'b00000, 8'd31, 5'b00000);
    chk("d_latency", lat, 32 + EXTRA);
    chk("d_npats", pats.size(), 31);
    chk("d_first", pats[0], 5'b11111);
    seen = '0; nnz = 0;
    foreach (pats[i]) begin
      seen[pats[i]] = 1'b1;
      if (pats[i] != 5'd0) nnz++;
    end
    ndist = $countones(seen);
    chk("d_distinct", ndist, 31);
    chk("d_nonzero", nnz, 31);
    chk("d_state32", d_pat, 5'b11111);
    chk("d_pass", d_pass, 1);

    // Abort in the 3rd RUN cycle, with a stray start in between.
    @(negedge clk);
    seed = 5'b11111; cnt = 8'd10; golden = '0; start = 1'b1;
    @(negedge clk);
    chk("e_pass_cleared", pass, 0);
    seed = 5'b00001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("e_pat3_no_restart", pattern, 5'b11100);
    chk("e_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("e_busy", busy, 0);
    chk("e_valid", pattern_valid, 0);
    chk("e_done", done, 0);
    chk("e_pass", pass, 0);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("e_no_done", ndone, 0);

    // Zero-length runs complete one cycle after start.
    run(5'b00000, 8'd0, 5'b00000);
    chk("f_latency", lat, 1);
    chk("f_sig", d_sig, 0);
    chk("f_pass", d_pass, 1);
    run(5'b00000, 8'd0, 5'b00011);
    chk("f2_pass", d_pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/atpg_bist_ctrl.md
# atpg_bist_ctrl

Sequencing controller for the ATPG pseudo-random pattern source. On a start request it seeds an internal maximal-length LFSR, drives a programmed number of patterns to the circuit under test (CUT), and compacts the CUT responses in a MISR. It then compares the final signature with a golden value and reports pass/fail. It sits between the test host (start, seed, golden signature) and the CUT pattern and response buses.

## Interface
- WIDTH, 5: pattern, response and signature width.
- TAPS, 5'b10100: feedback mask for both LFSR and MISR (x^5+x^3+1: bits 4 and 2).
- CNT_W, 8: width of the pattern-count input.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE.
- abort  in  1  cancel an active run.
- seed  in  WIDTH  LFSR seed; sampled at start.
- pattern_count  in  CNT_W  patterns per run; sampled at start.
- golden_sig  in  WIDTH  expected signature; sampled at start.
- cut_resp  in  WIDTH  CUT response to the current pattern.
- pattern  out  WIDTH  pattern driven to the CUT.
- pattern_valid  out  1  high while `pattern` is a live test pattern.
- busy  out  1  high from start acceptance until done or abort.
- done  out  1  one-cycle completion pulse.
- pass  out  1  signature matched golden; held until the next accepted start.
- signature  out  WIDTH  final MISR value; held until the next accepted start.

## Operation
- States: IDLE, RUN, DRAIN (only with the macro), DONE.
- IDLE:
  - start=1 with pattern_count≠0 → RUN. The LFSR loads `seed`, or 5'b11111 if `seed`=0 (lockup avoidance). MISR clears to 0. Pass and signature clear. Count is loaded.
  - start=1 with pattern_count=0 → DONE directly. signature=0, pass=(golden_sig==0).
- LFSR step: next = {cur[WIDTH-2:0], ^(cur & TAPS)}. Shifts on every RUN cycle.
- MISR step: next = {sig[WIDTH-2:0], ^(sig & TAPS)} ^ cut_resp. Absorbs on every RUN clock edge.
- RUN: pattern_valid=1. Count decrements each cycle. After the N-th pattern → DONE (or DRAIN).
- DONE: done=1 for exactly one cycle. pass=(final signature == sampled golden_sig). Next state is IDLE.
- Abort in RUN/DRAIN: next state is IDLE. done is not pulsed, pass=0, busy=0, signature holds its partial value.
- start while busy is ignored. abort in IDLE or DONE is ignored. If abort and the final RUN cycle coincide, abort wins.
- Reset, including mid-run: state=IDLE. pattern, pattern_valid, busy, done, pass and signature are all 0.
- `pattern` holds its last value after a run. LFSR period is 2^WIDTH−1 (31).

## Timing
- start high at edge E0 → pattern 1 (= seed) is visible in the cycle after E0, with pattern_valid=1 and busy=1.
- Pattern k is visible after edge E(k−1). cut_resp for pattern k must be valid at edge E(k), i.e. a combinational CUT path.
- done=1 in the cycle after E(N), with pass and signature valid in that same cycle. busy is low from E(N+1).
- Start-to-done latency: N+1 cycles. With pattern_count=0: done in the cycle after E0.
- Back-to-back runs: a new start is accepted at the first IDLE cycle.

## Configuration
- ATPG_RESP_REG_EN defined: cut_resp passes through one input register. The MISR absorbs the registered response for pattern k at E(k+1). DRAIN lasts one cycle after the last RUN cycle, and done moves one cycle later (latency N+2).
- Undefined: cut_resp is absorbed directly, there is no DRAIN state, and latency is N+1.

## Structure
- Package atpg_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the default TAPS and the lockup-substitute seed constant;
  - a pure function lfsr_step(cur, taps), shared by the LFSR and the MISR.
- Sub-module atpg_lfsr_gen (load, enable, seed, pattern) is instantiated once for the pattern source. The MISR stays inline in the controller.

## Test plan
- Reset: assert rst_n=0 mid-run → all outputs 0 and state IDLE immediately. After release, start works normally.
- seed=5'b11111, pattern_count=4, cut_resp=0 → patterns 11111, 11110, 11100, 11000. signature=00000. With golden_sig=00000, pass=1 and done arrives 5 cycles after E0.
- seed=5'b00001, pattern_count=1, cut_resp tied to pattern → signature=00001. golden_sig=00001 gives pass=1; golden_sig=00010 gives pass=0.
- seed=0, pattern_count=31 → first pattern 11111. All 31 patterns are distinct and non-zero, and the 32nd LFSR state equals 11111.
- Abort asserted in the 3rd RUN cycle → busy=0 next cycle, no done pulse, pass=0. A start pulsed mid-run is ignored. pattern_count=0 → done 1 cycle after E0.
- With ATPG_RESP_REG_EN: repeat the 2nd scenario → same patterns and signature, with done one cycle later.
